// File: rtl/cba_pkg.sv
// Shared helpers for the pipelined carry-bypass adder: parameter legality
// and block-count derivations used at elaboration time.
package cba_pkg;

  function automatic bit cba_params_ok(input int unsigned width,
                                       input int unsigned block,
                                       input int unsigned stages);
    if (width == 0 || block == 0 || stages == 0) return 1'b0;
    if ((width % block) != 0) return 1'b0;
    if (stages > (width / block)) return 1'b0;
    return ((width / block) % stages) == 0;
  endfunction

  function automatic int unsigned cba_nblk(input int unsigned width,
                                           input int unsigned block);
    return (block == 0) ? 0 : width / block;
  endfunction

  function automatic int unsigned cba_bps(input int unsigned width,
                                          input int unsigned block,
                                          input int unsigned stages);
    return (stages == 0) ? 0 : cba_nblk(width, block) / stages;
  endfunction

endpackage

// File: rtl/cba_block.sv
// Combinational BLOCK-bit ripple adder with a propagate-AND bypass on the
// carry out; also exposes the carry into its MSB for overflow detection.
module cba_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [BLOCK-1:0] p;
  logic             rc;

  always_comb begin
    p    = a ^ b;
    rc   = cin;
    sum  = '0;
    cmsb = 1'b0;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      sum[i] = p[i] ^ rc;
      cmsb   = rc;
      rc     = (a[i] & b[i]) | (p[i] & rc);
    end
    cout = (&p) ? cin : rc;
  end

endmodule

// File: rtl/cba_pipe_adder.sv
// Pipelined carry-bypass adder/subtractor: WIDTH/BLOCK bypass blocks spread
// over STAGES register ranks with a valid/ready handshake and result flags.
module cba_pipe_adder
  import cba_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned BPS = cba_bps(WIDTH, BLOCK, STAGES);
  localparam int unsigned SW  = BPS * BLOCK;

  if (!cba_params_ok(WIDTH, BLOCK, STAGES)) begin : g_param_check
    $error("cba_pipe_adder: illegal WIDTH/BLOCK/STAGES combination");
  end

  logic             advance;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_c;
  logic             fin_cm;
  logic             fin_v;

  // Whole pipeline moves or holds as one; bubbles are not collapsed.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar s = 0; s < STAGES; s++) begin : stg
    localparam int unsigned LO = s * SW;
    localparam int unsigned HI = LO + SW;

    logic [WIDTH-1:LO] sa;
    logic [WIDTH-1:LO] sb;
    logic              sc;
    logic              sv;
    logic [HI-1:0]     nsum;
    logic              nc;

    if (s == 0) begin : g_in
      assign sa = a;
      assign sb = b ^ {WIDTH{sub}};
      assign sc = cin ^ sub;
      assign sv = in_valid;
    end else begin : g_in
      assign sa            = stg[s-1].g_rank.ra;
      assign sb            = stg[s-1].g_rank.rb;
      assign sc            = stg[s-1].g_rank.rc;
      assign sv            = stg[s-1].g_rank.rv;
      assign nsum[LO-1:0]  = stg[s-1].g_rank.rsum;
    end

    for (genvar k = 0; k < BPS; k++) begin : blk
      logic             ci;
      logic             co;
      logic             cm;
      logic [BLOCK-1:0] bs;

      if (k == 0) begin : g_ci
        assign ci = sc;
      end else begin : g_ci
        assign ci = blk[k-1].co;
      end

      cba_block #(.BLOCK(BLOCK)) u_blk (
        .a    (sa[LO+k*BLOCK +: BLOCK]),
        .b    (sb[LO+k*BLOCK +: BLOCK]),
        .cin  (ci),
        .sum  (bs),
        .cout (co),
        .cmsb (cm)
      );

      assign nsum[LO+k*BLOCK +: BLOCK] = bs;
    end

    assign nc = blk[BPS-1].co;

    // Intermediate ranks carry only the operand bits later stages still need.
    if (s < STAGES - 1) begin : g_rank
      logic [WIDTH-1:HI] ra;
      logic [WIDTH-1:HI] rb;
      logic [HI-1:0]     rsum;
      logic              rc;
      logic              rv;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra   <= '0;
          rb   <= '0;
          rsum <= '0;
          rc   <= 1'b0;
          rv   <= 1'b0;
        end else if (advance) begin
          ra   <= sa[WIDTH-1:HI];
          rb   <= sb[WIDTH-1:HI];
          rsum <= nsum;
          rc   <= nc;
          rv   <= sv;
        end
      end
    end else begin : g_last
      assign fin_sum = nsum;
      assign fin_c   = nc;
      assign fin_cm  = blk[BPS-1].cm;
      assign fin_v   = sv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= fin_v;
      sum       <= fin_sum;
      cout      <= fin_c;
      overflow  <= fin_cm ^ fin_c;
      zero      <= ~|fin_sum;
    end
  end

endmodule

// File: tb/tb_cba_pipe_adder.sv
// Self-checking bench: four adder configurations share one stimulus stream,
// each scoreboarded against an arithmetic reference model.
module tb_cba_pipe_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] esum;
    logic        ecout;
    logic        eovf;
    logic        ezero;
  } vec_t;

  localparam int LAT [4] = '{2, 4, 1, 8};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a64 = '0;
  logic [63:0] b64 = '0;

  logic        ir0, ov0, c0, o0, z0;
  logic [31:0] s0;
  logic        ir1, ov1, c1, o1, z1;
  logic [15:0] s1;
  logic        ir2, ov2, c2, o2, z2;
  logic [31:0] s2;
  logic        ir3, ov3, c3, o3, z3;
  logic [63:0] s3;

  int vec = 0;
  int miss = 0;
  res_t q[4][$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  cba_pipe_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .a(a64[31:0]), .b(b64[31:0]), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(c0),
    .overflow(o0), .zero(z0));

  cba_pipe_adder #(.WIDTH(16), .BLOCK(4), .STAGES(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a64[15:0]), .b(b64[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(c1),
    .overflow(o1), .zero(z1));

  cba_pipe_adder #(.WIDTH(32), .BLOCK(8), .STAGES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .a(a64[31:0]), .b(b64[31:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(c2),
    .overflow(o2), .zero(z2));

  cba_pipe_adder #(.WIDTH(64), .BLOCK(4), .STAGES(8)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3),
    .a(a64), .b(b64), .cin(cin), .sub(sub),
    .out_valid(ov3), .out_ready(out_ready), .sum(s3), .cout(c3),
    .overflow(o3), .zero(z3));

  // Reference: exact integer arithmetic, then reduce to w bits and flags.
  function automatic res_t model(input int unsigned w, input logic [63:0] a,
                                 input logic [63:0] b, input logic ci,
                                 input logic sb);
    logic [63:0]        m;
    logic [67:0]        ua, ub, uc, u;
    logic signed [67:0] sa, sbv, sc, ex, hi, lo;
    res_t               r;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ua = {4'b0, a & m};
    ub = {4'b0, b & m};
    uc = {67'b0, ci};
    if (!sb) begin
      u      = ua + ub + uc;
      r.cout = u[w];
    end else begin
      u      = ua - ub - uc;
      r.cout = (ua >= ub + uc);
    end
    r.sum = u[63:0] & m;
    sa  = $signed(ua);
    sbv = $signed(ub);
    sc  = $signed(uc);
    if (a[w-1]) sa  = sa  - $signed(68'd1 << w);
    if (b[w-1]) sbv = sbv - $signed(68'd1 << w);
    ex = sb ? (sa - sbv - sc) : (sa + sbv + sc);
    hi = $signed(68'd1 << (w - 1)) - 68'sd1;
    lo = -$signed(68'd1 << (w - 1));
    r.ovf  = (ex > hi) || (ex < lo);
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int idx, input int unsigned w, input logic ir,
                     input logic ov, input res_t act);
    res_t e;
    if (!rst_n) begin
      q[idx].delete();
      return;
    end
    if (ov) begin
      if (q[idx].size() == 0) begin
        check($sformatf("dut%0d spurious out_valid", idx), 67'(ov), 67'd0);
      end else begin
        e = q[idx][0];
        check($sformatf("dut%0d result", idx), act, e);
        if (out_ready) void'(q[idx].pop_front());
        else check($sformatf("dut%0d stall in_ready", idx), 67'(ir), 67'd0);
      end
    end
    if (in_valid && ir) q[idx].push_back(model(w, a64, b64, cin, sub));
  endtask

  always @(negedge clk) mon(0, 32, ir0, ov0, {64'(s0), c0, o0, z0});
  always @(negedge clk) mon(1, 16, ir1, ov1, {64'(s1), c1, o1, z1});
  always @(negedge clk) mon(2, 32, ir2, ov2, {64'(s2), c2, o2, z2});
  always @(negedge clk) mon(3, 64, ir3, ov3, {s3, c3, o3, z3});

  task automatic directed(input vec_t v);
    int          lat [4];
    res_t        got;
    logic [3:0]  ovs;
    a64 = v.a; b64 = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    lat = '{default: 0};
    got = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) in_valid = 1'b0;
      ovs = {ov3, ov2, ov1, ov0};
      for (int i = 0; i < 4; i++) if (ovs[i] && lat[i] == 0) lat[i] = cyc;
      if (ov0 && lat[0] == cyc) got = {64'(s0), c0, o0, z0};
    end
    check("w32 directed result", got, {32'b0, v.esum, v.ecout, v.eovf, v.ezero});
    for (int i = 0; i < 4; i++)
      check($sformatf("dut%0d latency", i), 67'(lat[i]), 67'(LAT[i]));
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_8000_8000;
      3: return 64'h7FFF_FFFF_7FFF_7FFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int guard;
    tbl[0] = '{64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{64'h5, 64'h5, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{64'h0, 64'h1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{64'h8000_0000, 64'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{64'h1234_5678, 64'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{64'h0, 64'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{64'h7FFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

    // Reset state
    #12;
    check("reset out_valid", 67'(ov0), 67'd0);
    check("reset in_ready", 67'(ir0), 67'd1);
    check("reset outputs", {64'(s0), c0, o0, z0}, 67'd0);
    check("reset w64 out_valid", 67'(ov3), 67'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Directed vectors; first one is driven in the release cycle
    for (int i = 0; i < 10; i++) directed(tbl[i]);

    // Back-pressure stream
    out_ready = 1'($urandom_range(1));
    for (int n = 0; n < 8; n++) begin
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      in_valid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk); acc = ir0;
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(1));
        guard++;
      end
      if (!acc) check("backpressure accept timeout", 67'd0, 67'd1);
    end
    in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; out_ready = 1'($urandom_range(1)); end
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("backpressure drained", 67'(q[0].size()), 67'd0);

    // Reset with two operations in flight
    @(posedge clk); #1;
    a64 = 64'h11; b64 = 64'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a64 = 64'h33; b64 = 64'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in-flight out_valid before reset", 67'(ov0), 67'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 67'(ov0), 67'd0);
    check("mid reset in_ready", 67'(ir0), 67'd1);
    check("mid reset outputs", {64'(s0), c0, o0, z0}, 67'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    directed(tbl[6]);

    // Random regression across all configurations
    for (int cyc = 0; cyc < 12000; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(9) != 0);
      out_ready = ($urandom_range(7) != 0);
      a64 = pick(); b64 = pick();
      cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("dut%0d final drain", i), 67'(q[i].size()), 67'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/cba_pipe_adder.md
# cba_pipe_adder

Parametrised, pipelined carry-bypass adder/subtractor, the next generation of the fixed 32-bit, 4-bit-block carry-bypass adder in the Adders library. It splits a WIDTH-bit operation into BLOCK-bit carry-bypass blocks and distributes them over STAGES register ranks. A valid/ready handshake with back-pressure lets it sit between registered datapath units. It adds a subtract mode and registered carry, signed-overflow and zero flags.

## Interface
- WIDTH, 32: operand width; must be a multiple of BLOCK.
- BLOCK, 4: bits per carry-bypass block.
- STAGES, 2: pipeline ranks, 1..WIDTH/BLOCK; (WIDTH/BLOCK) must be divisible by STAGES.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  adder accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of the MSB block (sub: 1 = no borrow).
- overflow  out  1  signed (two's-complement) overflow.
- zero  out  1  sum == 0.

## Operation
- Operand transform at entry: b_eff = b ^ {WIDTH{sub}}, c0 = cin ^ sub, so sub computes a + ~b + ~cin = a - b - cin.
- NBLK = WIDTH/BLOCK blocks; BPS = NBLK/STAGES blocks per stage. Stage s evaluates blocks s*BPS .. s*BPS+BPS-1, ripple inside a block, bypass mux per block: carry_out = &(a^b_eff) over the block ? carry_in : ripple carry.
- Each rank registers: the sum bits computed so far, the carry into the next stage, a and b_eff bits not yet consumed, and a valid bit.
- Flags are computed in the last stage: cout = carry out of the MSB; overflow = carry into bit WIDTH-1 XOR cout; zero = ~|sum. All are registered with sum.
- Handshake: advance = ~out_valid | out_ready; in_ready = advance. When advance=1, every rank loads from its predecessor (rank 0 loads from the inputs, valid = in_valid). When advance=0, all ranks hold. Bubbles are not collapsed.
- A transfer occurs on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
- Results leave in acceptance order; no reordering and no drops.

## Timing
- Latency: STAGES cycles from input transfer to out_valid=1, given out_ready held at 1.
- Throughput: one operation per cycle while out_ready=1.
- Reset (asynchronous assert, any cycle, including mid-operation): all valid bits clear, and sum, cout, overflow, zero go to 0. Reset drives in_ready=1 and out_valid=0. In-flight operations are discarded.
- Reset deassertion: the first input can be accepted in the first clock edge after rst_n rises.
- out_valid=1 with out_ready=0: sum and all flags stay stable, and in_ready=0 in the same cycle (combinational from out_valid/out_ready).
- Simultaneous output and input transfer in one cycle is legal and sustains full throughput.
- in_valid=0 while advancing inserts a bubble that propagates as valid=0.
- STAGES=1 degenerates to one registered carry-bypass adder with latency 1.
- Wrap-around: sum is modulo 2^WIDTH. Carry and overflow are reported only via cout and overflow.

## Structure
- Package cba_pkg holds:
  - a function checking the parameter legality rules (elaboration-time assertion);
  - localparam helpers for NBLK and BPS.
- Sub-module cba_block (parameter BLOCK): combinational BLOCK-bit ripple block with propagate-AND bypass mux. Its ports are a, b, cin, sum, cout, plus carry-into-MSB for the overflow computation.
- Top level is generate loops of cba_block instances plus the STAGES register ranks and handshake logic.

## Test plan
- Defaults, out_ready=1. Input a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 → after 2 cycles sum=0x80000000, cout=0, overflow=1, zero=0.
- Defaults. Input a=0x00000005, b=0x00000005, cin=0, sub=1 → sum=0x00000000, cout=1, overflow=0, zero=1. Then a=0, b=1, sub=1 → sum=0xFFFFFFFF, cout=0 (borrow).
- Full-propagate bypass path: a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0, cout=1, zero=1. Repeat with WIDTH=16, BLOCK=4, STAGES=4 → sum=0x0000, cout=1, latency 4.
- Back-pressure: stream 8 random operations with out_ready toggling pseudo-randomly → results match a golden model in order, and sum/flags stay stable whenever out_valid=1 and out_ready=0.
- Reset mid-stream: assert rst_n=0 with 2 operations in flight → out_valid drops immediately; after release, no stale result appears and the next input yields a correct result after STAGES cycles.
- Random regression over {WIDTH,BLOCK,STAGES} ∈ {(32,4,2), (32,8,1), (64,4,8)}: 10k operations each, mixed add/sub → zero mismatches against the golden model.
